// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: load/store funct3 encodings and MMIO register offsets.
`default_nettype none

package rv32i_pkg;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_type_t;

  typedef enum logic [2:0] {
    ST_SB = 3'b000,
    ST_SH = 3'b001,
    ST_SW = 3'b010
  } store_type_t;

  localparam logic [3:0] MMIO_CYCLE = 4'h0;
  localparam logic [3:0] MMIO_FSTAT = 4'h4;
  localparam logic [3:0] MMIO_FADDR = 4'h8;

endpackage

`default_nettype wire

// File: rtl/dmem_ram.sv
// Word-organised data RAM with per-byte write enables and a combinational read port.
`default_nettype none

module dmem_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

`default_nettype wire

// File: rtl/data_mem_unit.sv
// Data memory unit: RAM plus a 16-byte MMIO window (cycle counter, fault status/address),
// with store lane/alignment handling and RV32I load formatting.
`default_nettype none

module data_mem_unit
  import rv32i_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_wr_en,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic [2:0]  store_type,
  input  logic [2:0]  load_type,
  output logic [31:0] dRdata,
  output logic        mem_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic        is_mmio;
  logic [3:0]  mmio_off;
  logic [3:0]  lanes;
  logic        misaligned;
  logic [31:0] store_data;
  logic        store_ok;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] cycle;
  logic [31:0] faddr;
  logic [31:0] mmio_rdata;
  logic [31:0] word_rd;
  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign is_mmio  = (dAddr[31:4] == MMIO_BASE[31:4]);
  assign mmio_off = {dAddr[3:2], 2'b00};

  always_comb begin
    lanes      = 4'b0000;
    misaligned = 1'b0;
    store_data = dWdata;
    case (store_type)
      ST_SB: begin
        lanes      = 4'b0001 << dAddr[1:0];
        store_data = {4{dWdata[7:0]}};
      end
      ST_SH: begin
        store_data = {2{dWdata[15:0]}};
        if (dAddr[0]) misaligned = 1'b1;
        else          lanes      = dAddr[1] ? 4'b1100 : 4'b0011;
      end
      ST_SW: begin
        if (dAddr[1:0] != 2'b00) misaligned = 1'b1;
        else                     lanes      = 4'b1111;
      end
      default: ;
    endcase
  end

  assign store_ok = d_wr_en && (lanes != 4'b0000);
  // Gating with reset keeps an in-flight RAM store from landing while reset is asserted.
  assign ram_we   = (store_ok && !is_mmio && reset) ? lanes : 4'b0000;

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (dAddr[AW+1:2]),
    .wdata (store_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle     <= 32'd0;
      mem_fault <= 1'b0;
      faddr     <= 32'd0;
    end else begin
      if (store_ok && is_mmio && mmio_off == MMIO_CYCLE && store_type == ST_SW)
        cycle <= dWdata;
      else
        cycle <= cycle + 32'd1;

      if (d_wr_en && misaligned) begin
        mem_fault <= 1'b1;
        if (!mem_fault) faddr <= dAddr;
      end else if (store_ok && is_mmio && mmio_off == MMIO_FSTAT) begin
        mem_fault <= 1'b0;
      end
    end
  end

  always_comb begin
    mmio_rdata = 32'd0;
    case (mmio_off)
      MMIO_CYCLE: mmio_rdata = cycle;
      MMIO_FSTAT: mmio_rdata = {31'd0, mem_fault};
      MMIO_FADDR: mmio_rdata = faddr;
      default:    mmio_rdata = 32'd0;
    endcase
  end

  assign word_rd  = is_mmio ? mmio_rdata : ram_rdata;
  assign shifted  = word_rd >> {dAddr[1:0], 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = dAddr[1] ? word_rd[31:16] : word_rd[15:0];

  always_comb begin
    dRdata = 32'd0;
    case (load_type)
      LD_LB:   dRdata = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  dRdata = {24'd0, byte_sel};
      LD_LH:   dRdata = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  dRdata = {16'd0, half_sel};
      LD_LW:   dRdata = word_rd;
      default: dRdata = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit.
`default_nettype none

module tb_data_mem_unit;

  logic        clk;
  logic        reset;
  logic        d_wr_en;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [2:0]  store_type;
  logic [2:0]  load_type;
  logic [31:0] dRdata;
  logic        mem_fault;

  int n_cmp;
  int n_bad;

  localparam logic [31:0] CYC = 32'hF000_0000;
  localparam logic [31:0] FST = 32'hF000_0004;
  localparam logic [31:0] FAD = 32'hF000_0008;

  data_mem_unit #(
    .DEPTH_WORDS(256),
    .MMIO_BASE  (32'hF000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d_wr_en    (d_wr_en),
    .dAddr      (dAddr),
    .dWdata     (dWdata),
    .store_type (store_type),
    .load_type  (load_type),
    .dRdata     (dRdata),
    .mem_fault  (mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    @(negedge clk);
    dAddr      = a;
    dWdata     = d;
    store_type = t;
    d_wr_en    = 1'b1;
    @(posedge clk);
    #1;
    d_wr_en = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] t, output logic [31:0] v);
    @(negedge clk);
    dAddr     = a;
    load_type = t;
    #1;
    v = dRdata;
  endtask

  logic [31:0] v;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    d_wr_en = 1'b0;
    dAddr = 32'd0;
    dWdata = 32'd0;
    store_type = 3'b010;
    load_type = 3'b010;

    // Reset state
    @(posedge clk);
    #1;
    check_eq("rst_fault", {31'd0, mem_fault}, 32'd0);
    dAddr = CYC; #1;
    check_eq("rst_cycle", dRdata, 32'd0);
    dAddr = FAD; #1;
    check_eq("rst_faddr", dRdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Load formatting
    do_store(32'h10, 32'h8765_4321, 3'b010);
    do_load(32'h13, 3'b000, v); check_eq("lb_13", v, 32'hFFFF_FF87);
    do_load(32'h13, 3'b100, v); check_eq("lbu_13", v, 32'h0000_0087);
    do_load(32'h12, 3'b001, v); check_eq("lh_12", v, 32'hFFFF_8765);
    do_load(32'h10, 3'b101, v); check_eq("lhu_10", v, 32'h0000_4321);
    do_load(32'h11, 3'b101, v); check_eq("lhu_11", v, 32'h0000_4321);
    do_load(32'h10, 3'b010, v); check_eq("lw_10", v, 32'h8765_4321);
    do_load(32'h10, 3'b011, v); check_eq("ld_undef", v, 32'd0);

    // Lane enables
    do_store(32'h20, 32'hFFFF_FFFF, 3'b010);
    do_store(32'h21, 32'hABCD_EF00, 3'b000);
    do_store(32'h22, 32'h5555_1234, 3'b001);
    do_load(32'h20, 3'b010, v); check_eq("lanes_20", v, 32'h1234_00FF);

    // Misaligned stores and fault registers
    do_store(32'h30, 32'h1111_1111, 3'b010);
    do_store(32'h31, 32'h0000_AAAA, 3'b001);
    do_load(32'h30, 3'b010, v); check_eq("mis_nowrite", v, 32'h1111_1111);
    check_eq("mis_fault", {31'd0, mem_fault}, 32'd1);
    do_load(FAD, 3'b010, v); check_eq("faddr_first", v, 32'h31);
    do_store(32'h45, 32'h0, 3'b010);
    do_load(FAD, 3'b010, v); check_eq("faddr_kept", v, 32'h31);
    do_load(FST, 3'b010, v); check_eq("fstat_set", v, 32'h1);
    do_load(FAD, 3'b100, v); check_eq("faddr_lbu", v, 32'h31);
    do_load(32'hF000_000A, 3'b001, v); check_eq("faddr_lh_hi", v, 32'h0);
    do_load(32'hF000_000C, 3'b010, v); check_eq("off_c", v, 32'h0);
    do_store(FAD, 32'h1234_5678, 3'b010);
    do_load(FAD, 3'b010, v); check_eq("faddr_ro", v, 32'h31);
    do_store(FST, 32'h0, 3'b010);
    check_eq("fstat_clr", {31'd0, mem_fault}, 32'd0);
    do_store(32'h30, 32'h0, 3'b011);
    do_load(32'h30, 3'b010, v); check_eq("st_undef_data", v, 32'h1111_1111);
    check_eq("st_undef_fault", {31'd0, mem_fault}, 32'd0);

    // Address wrap
    do_store(32'h400, 32'hDEAD_BEEF, 3'b010);
    do_load(32'h000, 3'b010, v); check_eq("wrap_0", v, 32'hDEAD_BEEF);

    // Cycle counter
    do_store(CYC, 32'hFFFF_FFFE, 3'b010);
    do_load(CYC, 3'b010, v); check_eq("cyc_load", v, 32'hFFFF_FFFE);
    do_load(CYC, 3'b010, v); check_eq("cyc_max", v, 32'hFFFF_FFFF);
    do_load(CYC, 3'b010, v); check_eq("cyc_wrap", v, 32'h0);
    do_store(CYC, 32'h100, 3'b010);
    do_store(CYC, 32'h55, 3'b000);
    do_load(CYC, 3'b010, v); check_eq("cyc_sb_ign", v, 32'h101);

    // Asynchronous reset mid-operation
    do_store(32'h33, 32'h0, 3'b001);
    do_store(CYC, 32'h50, 3'b010);
    check_eq("pre_fault", {31'd0, mem_fault}, 32'd1);
    dAddr = CYC; load_type = 3'b010; #1;
    check_eq("pre_cyc", dRdata, 32'h50);
    #1;
    reset = 1'b0;
    #1;
    check_eq("arst_fault", {31'd0, mem_fault}, 32'd0);
    dAddr = CYC; #0.5;
    check_eq("arst_cycle", dRdata, 32'd0);
    dAddr = FAD; #0.5;
    check_eq("arst_faddr", dRdata, 32'd0);
    @(negedge clk);
    dAddr = 32'h10; #1;
    check_eq("arst_ram10", dRdata, 32'h8765_4321);
    dAddr = 32'h0; #1;
    check_eq("arst_ram0", dRdata, 32'hDEAD_BEEF);
    @(negedge clk);
    reset = 1'b1;
    do_store(32'h44, 32'hCAFE_F00D, 3'b010);
    do_load(32'h44, 3'b010, v); check_eq("post_rst_st", v, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: RAM depth in 32-bit words, power of two.
REQ-002 Parameter MMIO_BASE, default 32'hF000_0000: base of the 16-byte MMIO window.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 d_wr_en  input  1  store strobe from the core, sampled on the rising clk edge.
REQ-006 dAddr  input  32  byte address from the core.
REQ-007 dWdata  input  32  store data; the active lanes come from the low bits.
REQ-008 store_type  input  3  store funct3: 000 SB, 001 SH, 010 SW.
REQ-009 load_type  input  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 dRdata  output  32  formatted load data returned to the core.
REQ-011 mem_fault  output  1  sticky misaligned-store flag.

Function
REQ-012 Decode: dAddr[31:4]==MMIO_BASE[31:4] selects MMIO; any other address selects RAM.
REQ-013 RAM word index is dAddr[log2(DEPTH_WORDS)+1:2], so addresses wrap modulo RAM size.
REQ-014 Reads are combinational, with zero latency, so a single-cycle core can use them.
REQ-015 Stores commit on the rising edge where d_wr_en=1 and are visible to reads in the next cycle.
REQ-016 Store lane enables:
- SB writes byte dAddr[1:0] with dWdata[7:0].
- SH writes halfword dAddr[1] with dWdata[15:0].
- SW writes all four bytes.
- All other lanes are unchanged.
REQ-017 Store alignment:
- SH with dAddr[0]=1 is misaligned.
- SW with dAddr[1:0]!=0 is misaligned.
- A misaligned store writes nothing.
REQ-018 An undefined store_type with d_wr_en=1 writes nothing and does not fault.
REQ-019 Load formatting:
- LB/LBU select byte dAddr[1:0].
- LH/LHU select halfword dAddr[1]; dAddr[0] is ignored.
- LB/LH sign-extend; LBU/LHU zero-extend.
- LW returns the full word.
- An undefined load_type returns 0.
REQ-020 MMIO offset 0x0, CYCLE: 32-bit counter.
- Increments by 1 every cycle.
- Wraps from FFFF_FFFF to 0.
REQ-021 A SW to CYCLE loads dWdata; on the same edge the load wins over the increment.
REQ-022 MMIO offset 0x4, FSTAT: bit0 = mem_fault, other bits read 0.
- Any aligned store to FSTAT clears it.
REQ-023 MMIO offset 0x8, FADDR: holds the dAddr of the first misaligned store since the last clear.
- FADDR is read-only.
REQ-024 Misaligned store:
- Sets mem_fault.
- Captures FADDR only if mem_fault was 0.
- Later faults do not overwrite FADDR.
REQ-025 A misaligned store and a clear to FSTAT cannot occur on the same edge (single port), so there is no conflict case.
REQ-026 Offset 0xC and non-SW stores to CYCLE:
- Offset 0xC reads 0.
- SB or SH to CYCLE is ignored.
- Stores to FADDR or to 0xC are ignored.
REQ-027 MMIO loads apply the same lane formatting as RAM loads.

Reset
REQ-028 While reset=0: CYCLE=0, mem_fault=0, FSTAT=0, FADDR=0.
REQ-029 RAM contents are not reset and are preserved across reset.
REQ-030 RAM reads during reset still return RAM contents; MMIO reads return the reset values.
REQ-031 A store presented on the edge where reset is released commits normally.
REQ-032 Asserting reset mid-operation aborts any pending store and takes effect immediately, with no clock needed.

Structure
REQ-033 Shared package rv32i_pkg holds:
- the load and store funct3 enums;
- MMIO offset constants (CYCLE, FSTAT, FADDR).
REQ-034 Storage sits in one sub-module, dmem_ram.
- Ports: 4-bit byte-enable write, combinational word read.
- It contains no reset logic.
REQ-035 Alignment check, lane-enable generation, load formatter, and MMIO registers stay in data_mem_unit.

Verification
REQ-036 SW 0x8765_4321 @0x10, then loads @0x10 → required responses:
- LB @0x13 → FFFF_FF87.
- LBU @0x13 → 0000_0087.
- LH @0x12 → FFFF_8765.
- LHU @0x10 → 0000_4321.
REQ-037 SW FFFF_FFFF @0x20, SB 0x00 @0x21, SH 0x1234 @0x22 → LW @0x20 returns 1234_00FF.
REQ-038 SH 0xAAAA @0x31 → LW @0x30 unchanged, mem_fault=1, FADDR=0x31.
- Then SW @0x45 → FADDR stays 0x31.
- Then SW 0 to FSTAT → mem_fault=0.
REQ-039 With DEPTH_WORDS=256: SW 0xDEAD_BEEF @0x400 → LW @0x000 returns DEAD_BEEF.
REQ-040 SW FFFF_FFFE to CYCLE, then read on following cycles → required responses:
- Successive reads return FFFF_FFFF, then 0000_0000.
- SB to CYCLE has no effect on its value.
REQ-041 Pulse reset low between clock edges while mem_fault=1 and CYCLE=0x50:
- mem_fault, CYCLE and FADDR go to 0 immediately.
- A word previously stored in RAM still reads back intact.
